// File: rtl/pts_seq_ctrl.sv
// Control sequencer for the 20-word parallel-to-serial converter: one load per
// frame, then exactly NWORDS ready-gated out strobes, plus a registered dataout sideband.
module pts_seq_ctrl #(
    parameter int NWORDS = 20,
    parameter int CW     = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ready,
    output logic          load,
    output logic          out,
    output logic          dout_valid,
    output logic [CW-1:0] word_idx,
    output logic          busy,
    output logic          done,
    output logic          overrun
);

    localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_dout_valid;
    logic [CW-1:0] r_word_idx;
    logic          r_overrun;
    logic          w_load;
    logic          w_out;
    logic          w_done;
    logic          w_busy;

    // Next-state, counter and converter strobes; the terminal compare ends the frame so cnt never wraps
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_out       = 1'b0;
        w_done      = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                w_load      = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                w_out = ready;
                if (ready) begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                    if (r_cnt == LAST_IDX) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_state_nxt = S_SHIFT;
                    end
                end else begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_DRAIN: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_busy      = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and word counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Sideband registers track the converter's one-cycle registered dataout
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout_valid <= 1'b0;
            r_word_idx   <= '0;
            r_overrun    <= 1'b0;
        end else begin
            r_dout_valid <= w_out;
            if (w_out) begin
                r_word_idx <= r_cnt;
            end else begin
                r_word_idx <= r_word_idx;
            end
            r_overrun <= start && (r_state != S_IDLE);
        end
    end

    assign load       = w_load;
    assign out        = w_out;
    assign done       = w_done;
    assign busy       = w_busy;
    assign dout_valid = r_dout_valid;
    assign word_idx   = r_word_idx;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_pts_seq_ctrl.sv
// Scoreboard bench for pts_seq_ctrl with a behavioural converter and a
// frame-level reference model (start cycle plus count of words sent).
module tb_pts_seq_ctrl;

    localparam int NWORDS = 20;
    localparam int CW     = 5;

    logic          clk = 1'b0;
    logic          rst, start, ready;
    logic          load, out, dout_valid, busy, done, overrun;
    logic [CW-1:0] word_idx;

    pts_seq_ctrl #(.NWORDS(NWORDS), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .load(load), .out(out), .dout_valid(dout_valid), .word_idx(word_idx),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    bit en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rst) en <= 1'b1;

    task automatic chk(input string name, input longint act, input longint exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Behavioural converter: captures bank on load, shifts one word per out strobe
    logic [24:0] datain [NWORDS];
    logic [24:0] conv_bank [NWORDS];
    logic [24:0] conv_dout = '0;
    int          conv_idx  = 0;
    always @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < NWORDS; k++) conv_bank[k] <= datain[k];
            conv_idx <= 0;
        end else if (out) begin
            conv_dout <= conv_bank[conv_idx];
            if (conv_idx < NWORDS - 1) conv_idx <= conv_idx + 1;
        end
    end

    typedef struct {
        int          cyc;
        int          idx;
        logic [24:0] data;
    } wexp_t;
    wexp_t q[$];
    int    load_cycs[$];
    int    done_cycs[$];

    // Reference model: a frame is its start cycle and the number of words sent so far
    bit          m_in   = 1'b0;
    int          m_s    = 0;
    int          m_sent = 0;
    bit          m_ovr  = 1'b0;
    int          m_last = 0;
    logic [24:0] m_bank [NWORDS];
    always @(negedge clk) begin
        bit e_load, e_out, e_done, was;
        if (en) begin
            e_load = m_in && (cyc == m_s + 1);
            e_out  = m_in && (cyc >= m_s + 2) && (m_sent < NWORDS) && ready;
            e_done = m_in && (m_sent == NWORDS);
            chk("load", load, e_load);
            chk("out", out, e_out);
            chk("done", done, e_done);
            chk("busy", busy, m_in);
            chk("overrun", overrun, m_ovr);
            chk("word_idx_hold", word_idx, m_last);
            was = m_in;
            if (rst) begin
                m_in   = 1'b0;
                m_ovr  = 1'b0;
                m_last = 0;
            end else begin
                m_ovr = start && was;
                if (e_out) begin
                    q.push_back('{cyc + 1, m_sent, m_bank[m_sent]});
                    m_last = m_sent;
                    m_sent++;
                end
                if (e_done) m_in = 1'b0;
                if (!was && start) begin
                    m_in   = 1'b1;
                    m_s    = cyc;
                    m_sent = 0;
                    for (int k = 0; k < NWORDS; k++) m_bank[k] = datain[k];
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever a word is presented
    always @(negedge clk) begin
        wexp_t e;
        if (en) begin
            if (load) load_cycs.push_back(cyc);
            if (done) done_cycs.push_back(cyc);
            if (dout_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("word_cycle", cyc, e.cyc);
                    chk("word_index", word_idx, e.idx);
                    chk("word_data", conv_dout, e.data);
                end
            end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                chk("missing_word", 0, 1);
            end
        end
    end

    task automatic drive(input bit st, input bit rd, input bit rs);
        start = st;
        ready = rd;
        rst   = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic set_bank(input int base);
        for (int k = 0; k < NWORDS; k++) datain[k] = 25'(base + k);
    endtask

    initial begin
        int  s1, s2, s3, s4, s5;
        bit  prev_st;
        bit  st;
        rst = 1'b1; start = 1'b0; ready = 1'b0;
        set_bank(32'h0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        chk("reset_dout_valid", dout_valid, 0);
        chk("reset_word_idx", word_idx, 0);
        drive(1'b0, 1'b1, 1'b0);

        // Frame 1 with an overrun start at relative cycle 10
        set_bank(32'h100);
        s1 = cyc;
        for (int r = 0; r < 23; r++) drive(r == 0 || r == 10, 1'b1, 1'b0);

        // Frame 2 back-to-back at the first IDLE cycle, with backpressure
        set_bank(32'h200);
        s2 = cyc;
        for (int r = 0; r < 28; r++) drive(r == 0, !(r == 5 || r == 6 || r == 15), 1'b0);

        // Frame 3 aborted by reset at relative cycle 12
        set_bank(32'h300);
        s3 = cyc;
        for (int r = 0; r < 13; r++) drive(r == 0, 1'b1, r == 12);
        for (int r = 0; r < 3; r++) drive(1'b0, 1'b1, 1'b0);

        // Frame 4 full frame after the abort
        set_bank(32'h400);
        s4 = cyc;
        for (int r = 0; r < 26; r++) drive(r == 0, 1'b1, 1'b0);

        // Frame 5 with ready held low for 100 cycles in SHIFT
        set_bank(32'h500);
        s5 = cyc;
        for (int r = 0; r < 130; r++) drive(r == 0, !(r >= 8 && r < 108), 1'b0);

        chk("f1_load_cycle", (load_cycs.size() > 0) ? load_cycs[0] : -1, s1 + 1);
        chk("f1_done_cycle", (done_cycs.size() > 0) ? done_cycs[0] : -1, s1 + 22);
        chk("f2_load_cycle", (load_cycs.size() > 1) ? load_cycs[1] : -1, s1 + 24);
        chk("f2_done_cycle", (done_cycs.size() > 1) ? done_cycs[1] : -1, s2 + 25);
        chk("f3_load_cycle", (load_cycs.size() > 2) ? load_cycs[2] : -1, s3 + 1);
        chk("f4_done_cycle", (done_cycs.size() > 2) ? done_cycs[2] : -1, s4 + 22);
        chk("f5_done_cycle", (done_cycs.size() > 3) ? done_cycs[3] : -1, s5 + 122);

        // Random traffic; bank held during the cycle after any start
        prev_st = 1'b0;
        for (int r = 0; r < 2000; r++) begin
            if (!prev_st) begin
                for (int k = 0; k < NWORDS; k++) datain[k] = 25'($urandom);
            end
            st = ($urandom_range(0, 9) == 0);
            drive(st, $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
            prev_st = st;
        end
        for (int r = 0; r < 40; r++) drive(1'b0, 1'b1, 1'b0);
        chk("scoreboard_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/pts_seq_ctrl.md
# pts_seq_ctrl

Sequencer for the 20-word parallel-to-serial converter (25-bit words) at the output of the result datapath. On a `start` pulse it issues one `load` cycle to capture the parallel bank, then exactly NWORDS `out` strobes gated by downstream `ready`. It also produces a `dout_valid` / `word_idx` sideband aligned with the converter's registered `dataout`. It owns all converter control; nothing else drives `load` or `out`.

## Interface
- NWORDS, 20, words per frame; must match the converter bank depth
- CW, 5, counter/index width; 2^CW >= NWORDS
- clk  input  1  rising-edge clock shared with the converter
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse; parallel bank inputs valid this cycle and held until `load` is seen
- ready  input  1  downstream can accept a word this cycle
- load  output  1  to converter `load`; high exactly one cycle per frame
- out  output  1  to converter `out`; one strobe advances the converter by one word
- dout_valid  output  1  converter `dataout` holds a new word this cycle
- word_idx  output  CW  index (0..NWORDS-1) of the word qualified by `dout_valid`
- busy  output  1  frame in progress (state != IDLE)
- done  output  1  one-cycle pulse while the last word is valid
- overrun  output  1  one-cycle pulse: `start` arrived while busy and was dropped

## Operation
- States: IDLE, LOAD, SHIFT, DRAIN.
- IDLE: `start`=1 -> LOAD; otherwise stay.
- LOAD: `load`=1 (combinational from state); cnt <= 0; -> SHIFT unconditionally.
- SHIFT: `out` = `ready` (combinational). When `out`=1, cnt <= cnt+1. When `out`=1 and cnt==NWORDS-1 -> DRAIN. `ready`=0 stalls with no strobe and cnt held.
- DRAIN: `done`=1 (combinational); -> IDLE.
- `load` and `out` are never high in the same cycle.
- Sideband registers: dout_valid <= out; word_idx <= cnt when out=1, otherwise held. This matches the converter's one-cycle registered `dataout`.
- `start` in LOAD/SHIFT/DRAIN: ignored, frame unaffected, `overrun` pulses next cycle (registered).
- `start` in the same cycle as the DRAIN->IDLE transition is dropped. `start` must arrive when state is IDLE.
- Exactly NWORDS `out` strobes per frame. The converter index saturates and only clears on `load`, so extra strobes are forbidden.
- cnt is CW bits. No wrap: the compare at NWORDS-1 terminates the frame.

## Timing
- Reset (rst=1 at an edge): state IDLE, cnt 0, dout_valid 0, word_idx 0, overrun 0. Combinational outputs load, out, done, busy evaluate to 0.
- Reset mid-frame aborts immediately with no further strobes. The converter buffer contents are irrelevant; the next frame reloads.
- Unstalled frame, `start` at cycle 0:
  - load=1 in cycle 1.
  - out=1 in cycles 2..NWORDS+1.
  - dout_valid=1 in cycles 3..NWORDS+2 with word_idx 0..NWORDS-1.
  - done=1 in cycle NWORDS+2 (22 for default), coincident with the last dout_valid.
  - IDLE in cycle NWORDS+3.
- Minimum start-to-start spacing: NWORDS+3 cycles.
- Each stall cycle (ready=0 in SHIFT) adds one cycle and produces a dout_valid=0 bubble one cycle later. dataout and word_idx hold during the bubble.
- busy=1 from cycle 1 through DRAIN inclusive.

## Test plan
- Reset then single frame, ready=1, datain_k = k+0x100 (word k): load only in cycle 1; 20 dout_valid in cycles 3..22; dataout = 0x100..0x113 in order with word_idx 0..19; done only in cycle 22; busy falls in cycle 23.
- Backpressure: ready=0 in cycles 5,6 and 15: 20 strobes total; dout_valid=0 in cycles 6,7,16; data order intact; done in cycle 25.
- Overrun: second `start` in cycle 10 of a frame: overrun=1 in cycle 11; the frame completes unchanged; no second load.
- Back-to-back: `start` again in cycle 23 (first IDLE): load in cycle 24; second frame data correct, including the converter index restart at word 0.
- Reset mid-frame: rst=1 in cycle 12: from cycle 13, out=0, dout_valid=0, busy=0, no done. A new `start` then yields a full correct 20-word frame.
- ready held 0 for 100 cycles in SHIFT: no strobes, busy=1, cnt held. Releasing ready resumes at the next word index.
